// File: rtl/store_buffer.sv
// store_buffer
//   Write-posting store buffer between the MEM stage and data_memory.
//   Up to DEPTH stores are queued in a circular FIFO and drained to memory
//   one per cycle whenever the memory port is not taken by a load. Loads
//   normally own the port; a load that hits a queued store is either served
//   from the buffer or stalled, depending on the build.
//
//   Build option:
//     STORE_BUF_FWD_EN  defined   -> the youngest matching entry forwards its
//                                    data to ld_data; stall only when full.
//                       undefined -> no forwarding; a matching load stalls while
//                                    the head drains, until no entry matches.
//
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     st_valid/st_addr/st_data        store request from MEM
//     st_ready                        store accepted this cycle (= !full)
//     ld_valid/ld_addr                load request from MEM
//     ld_data/ld_stall                load result / hold request
//     mem_write/mem_address/
//     mem_write_data/mem_read_data    data_memory port (combinational read)
//     count/empty/full                occupancy status (registered state only)
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_stall,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_write_data,
    input  logic [DATA_W-1:0]        mem_read_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    logic hit;
    logic load_on_port;
    logic drain;
    logic push;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = !full;

`ifdef STORE_BUF_FWD_EN
    logic [DATA_W-1:0] fwd_data;

    // Walk from oldest to youngest so the last (youngest) match wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q && addr_q[PW'(head_q + PW'(k))] == ld_addr) begin
                hit      = 1'b1;
                fwd_data = data_q[PW'(head_q + PW'(k))];
            end
        end
    end

    assign ld_stall = ld_valid && full;
    assign ld_data  = hit ? fwd_data : mem_read_data;
`else
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q && addr_q[PW'(head_q + PW'(k))] == ld_addr) begin
                hit = 1'b1;
            end
        end
    end

    // A matching load waits for the older stores to reach memory.
    assign ld_stall = ld_valid && (full || hit);
    assign ld_data  = mem_read_data;
`endif

    // A stalled load gives up the port, so the head drains in its place.
    assign load_on_port = ld_valid && !ld_stall;
    assign drain        = !empty && !load_on_port;
    // No push while full, even if the head drains the same cycle.
    assign push         = st_valid && !full;

    always_comb begin
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (drain) begin
            mem_write      = 1'b1;
            mem_address    = addr_q[head_q];
            mem_write_data = data_q[head_q];
        end else if (load_on_port) begin
            mem_address = ld_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= PW'(tail_q + 1'b1);
            end
            if (drain) begin
                head_q <= PW'(head_q + 1'b1);
            end
            case ({push, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end

endmodule
